// File: rtl/fsm_rx.sv
// Serial frame receiver for the one-bit-per-clock 11-bit frame link.
// A frame is a start bit (0), eight data bits with data[0] first, a parity bit and a
// stop bit (1). The line idles high.
//
// Ports:
//   clk         system clock, all logic on posedge
//   rst_n       synchronous active-low reset
//   rx_in       serial line, synchronous to clk, idle high
//   data_out    received byte, data_out[0] = first data bit on the line
//   data_valid  one-cycle strobe when data_out / parity_err / frame_err are updated
//   parity_err  parity mismatch on the last frame, held until the next frame
//   frame_err   stop bit sampled low on the last frame, held until the next frame
//   rx_busy     high while a frame is being received (START..STOP)
module fsm_rx #(
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter bit          PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    output logic [0:7] data_out,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       rx_busy
);

    // Start-bit confirmation offset from the start edge.
    localparam int unsigned HalfBit  = (CLKS_PER_BIT - 1) / 2;
    localparam int unsigned CntW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned HalfIdx  = (HalfBit > 0) ? HalfBit - 1 : 0;
    localparam logic [CntW-1:0] CntLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(HalfIdx);

    typedef enum logic [2:0] {
        StSync,
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreakWait
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [0:7]      shift_q, shift_d;
    logic            par_q, par_d;
    logic [0:7]      data_out_q, data_out_d;
    logic            data_valid_q, data_valid_d;
    logic            parity_err_q, parity_err_d;
    logic            frame_err_q, frame_err_d;
    logic            rx_busy_q, rx_busy_d;
    logic            sample;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;

        // In the timed states a bit is sampled once every CLKS_PER_BIT edges.
        sample    = (clk_cnt_q == CntLast);
        clk_cnt_d = sample ? '0 : clk_cnt_q + 1'b1;

        unique case (state_q)
            StSync: begin
                if (rx_in) state_d = StIdle;
            end
            StIdle: begin
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                if (!rx_in) begin
                    // With no mid-bit offset the start edge itself is the confirmation.
                    state_d = (HalfBit == 0) ? StData : StStart;
                end
            end
            StStart: begin
                if (clk_cnt_q == HalfLast) begin
                    clk_cnt_d = '0;
                    state_d   = rx_in ? StIdle : StData;
                end
            end
            StData: begin
                if (sample) begin
                    shift_d[bit_cnt_q] = rx_in;
                    bit_cnt_d          = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = StParity;
                end
            end
            StParity: begin
                if (sample) begin
                    par_d   = rx_in;
                    state_d = StStop;
                end
            end
            StStop: begin
                if (sample) begin
                    data_out_d   = shift_q;
                    parity_err_d = (^shift_q) ^ par_q ^ PARITY_ODD;
                    frame_err_d  = ~rx_in;
                    data_valid_d = 1'b1;
                    state_d      = rx_in ? StIdle : StBreakWait;
                end
            end
            StBreakWait: begin
                if (rx_in) state_d = StIdle;
            end
            default: state_d = StSync;
        endcase

        rx_busy_d = (state_d == StStart) || (state_d == StData) ||
                    (state_d == StParity) || (state_d == StStop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StSync;
            clk_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            rx_busy_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            rx_busy_q    <= rx_busy_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign rx_busy    = rx_busy_q;

endmodule

// File: tb/tb_fsm_rx.sv
// Bench for fsm_rx: two one-clock-per-bit receivers (even and odd parity) share line rx1,
// a four-clocks-per-bit receiver listens on rx4. A frame-level model predicts the strobe
// edge, byte and flags of every frame sent, and a negedge process compares every cycle.
module tb_fsm_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, rx1, rx4;
    logic [0:7] e_d, o_d, s_d;
    logic e_v, e_pe, e_fe, e_b;
    logic o_v, o_pe, o_fe, o_b;
    logic s_v, s_pe, s_fe, s_b;

    fsm_rx #(.CLKS_PER_BIT(1), .PARITY_ODD(1'b0)) u_even (
        .clk(clk), .rst_n(rst_n), .rx_in(rx1), .data_out(e_d), .data_valid(e_v),
        .parity_err(e_pe), .frame_err(e_fe), .rx_busy(e_b));
    fsm_rx #(.CLKS_PER_BIT(1), .PARITY_ODD(1'b1)) u_odd (
        .clk(clk), .rst_n(rst_n), .rx_in(rx1), .data_out(o_d), .data_valid(o_v),
        .parity_err(o_pe), .frame_err(o_fe), .rx_busy(o_b));
    fsm_rx #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b0)) u_slow (
        .clk(clk), .rst_n(rst_n), .rx_in(rx4), .data_out(s_d), .data_valid(s_v),
        .parity_err(s_pe), .frame_err(s_fe), .rx_busy(s_b));

    typedef struct {
        int         at;   // edge whose outputs carry the strobe
        logic [0:7] d;
        logic       pe;   // even-parity violation
        logic       fe;
    } ev_t;

    ev_t q1[$];
    ev_t q4[$];
    int  edge_n = 0;
    int  n_chk = 0;
    int  n_err = 0;
    bit  chk_en = 1'b0;

    // Held model outputs, busy windows [bs, be) in edge numbers.
    logic [0:7] h1_d, h4_d;
    logic       h1_pe, h1_po, h1_fe, h4_pe, h4_fe;
    int         bs1, be1, bs4, be4;
    logic       ev1, ev4;
    int         t0;
    logic [0:7] pf;
    logic [0:7] lb [4];

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic tick(input logic v1, input logic v4);
        rx1 = v1;
        rx4 = v4;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b1);
    endtask

    task automatic clear_model();
        q1.delete();
        q4.delete();
        h1_d = '0; h1_pe = 1'b0; h1_po = 1'b0; h1_fe = 1'b0;
        h4_d = '0; h4_pe = 1'b0; h4_fe = 1'b0;
        bs1 = 0; be1 = 0; bs4 = 0; be4 = 0;
    endtask

    // Send one frame; the model entry is derived from the frame contents and timing alone.
    task automatic send(input bit on4, input logic [0:7] d, input logic pbit, input logic stopb);
        int         cpb;
        int         half;
        int         t;
        logic [0:10] bits;
        ev_t        e;
        cpb  = on4 ? 4 : 1;
        half = (cpb - 1) / 2;
        t    = edge_n + 1;
        bits = {1'b0, d, pbit, stopb};
        e.at = t + half + 10 * cpb;
        e.d  = d;
        e.pe = (($countones(d) + int'(pbit)) % 2) == 1;
        e.fe = ~stopb;
        if (on4) begin
            q4.push_back(e); bs4 = t; be4 = e.at;
        end else begin
            q1.push_back(e); bs1 = t; be1 = e.at;
        end
        for (int j = 0; j < 11; j++) begin
            for (int c = 0; c < cpb; c++) begin
                if (on4) tick(1'b1, bits[j]);
                else tick(bits[j], 1'b1);
            end
        end
    endtask

    function automatic logic evp(input logic [0:7] d);
        return ($countones(d) % 2) == 1;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            ev1 = 1'b0;
            if (q1.size() > 0 && q1[0].at == edge_n) begin
                ev1   = 1'b1;
                h1_d  = q1[0].d;
                h1_pe = q1[0].pe;
                h1_po = ~q1[0].pe;
                h1_fe = q1[0].fe;
                void'(q1.pop_front());
            end
            ev4 = 1'b0;
            if (q4.size() > 0 && q4[0].at == edge_n) begin
                ev4   = 1'b1;
                h4_d  = q4[0].d;
                h4_pe = q4[0].pe;
                h4_fe = q4[0].fe;
                void'(q4.pop_front());
            end
            chk("even_valid", e_v, ev1);
            chk("even_data", e_d, h1_d);
            chk("even_perr", e_pe, h1_pe);
            chk("even_ferr", e_fe, h1_fe);
            chk("even_busy", e_b, (edge_n >= bs1) && (edge_n < be1));
            chk("odd_valid", o_v, ev1);
            chk("odd_data", o_d, h1_d);
            chk("odd_perr", o_pe, h1_po);
            chk("odd_ferr", o_fe, h1_fe);
            chk("odd_busy", o_b, (edge_n >= bs1) && (edge_n < be1));
            chk("slow_valid", s_v, ev4);
            chk("slow_data", s_d, h4_d);
            chk("slow_perr", s_pe, h4_pe);
            chk("slow_ferr", s_fe, h4_fe);
            chk("slow_busy", s_b, (edge_n >= bs4) && (edge_n < be4));
        end
    end

    initial begin
        rst_n = 1'b0;
        rx1   = 1'b0;
        rx4   = 1'b1;
        clear_model();
        lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h5A; lb[3] = 8'hC3;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        chk("rst_data", e_d, 8'h00);
        chk("rst_busy", e_b, 1'b0);
        chk("rst_valid", s_v, 1'b0);

        // Line held low out of reset must not look like a start bit.
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
        idle(2);

        // Basic frame: byte 10110010, parity 0, stop 1.
        send(1'b0, 8'b10110010, 1'b0, 1'b1);
        chk("t1_strobe", e_v, 1'b1);
        chk("t1_data", e_d, 8'b10110010);
        chk("t1_perr", e_pe, 1'b0);
        chk("t1_ferr", e_fe, 1'b0);
        idle(2);

        // Same frame, parity flipped.
        send(1'b0, 8'b10110010, 1'b1, 1'b1);
        chk("t2_data", e_d, 8'b10110010);
        chk("t2_perr_even", e_pe, 1'b1);
        chk("t2_perr_odd", o_pe, 1'b0);
        idle(2);

        // Stop bit low, line held low, then a good frame for A5.
        send(1'b0, 8'b10110010, 1'b0, 1'b0);
        chk("t3_ferr", e_fe, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        send(1'b0, 8'hA5, evp(8'hA5), 1'b1);
        chk("t3_data", e_d, 8'hA5);
        chk("t3_ferr_clr", e_fe, 1'b0);
        idle(2);

        // Transmitter-style stream with 2-cycle high gaps.
        for (int i = 0; i < 4; i++) begin
            send(1'b0, lb[i], evp(lb[i]), 1'b1);
            idle(2);
        end
        chk("lb_last", e_d, 8'hC3);

        // Zero idle cycles between frames.
        send(1'b0, 8'h12, evp(8'h12), 1'b1);
        send(1'b0, 8'h34, evp(8'h34), 1'b1);
        chk("b2b_data", e_d, 8'h34);
        idle(3);

        // Four clocks per bit: one-cycle glitch, then a real frame.
        t0  = edge_n + 1;
        bs4 = t0;
        be4 = t0 + 1;
        tick(1'b1, 1'b0);
        chk("glitch_busy_hi", s_b, 1'b1);
        tick(1'b1, 1'b1);
        chk("glitch_busy_lo", s_b, 1'b0);
        idle(4);
        send(1'b1, 8'h3C, evp(8'h3C), 1'b1);
        chk("slow_3c", s_d, 8'h3C);
        chk("slow_3c_perr", s_pe, 1'b0);
        idle(4);

        // Reset while the fifth data bit is sampled.
        pf  = 8'h81;
        t0  = edge_n + 1;
        bs1 = t0;
        be1 = t0 + 1000;
        tick(1'b0, 1'b1);
        for (int k = 0; k < 4; k++) tick(pf[k], 1'b1);
        rx1   = pf[4];
        rst_n = 1'b0;
        @(posedge clk); #1;
        clear_model();
        chk("mid_rst_data", e_d, 8'h00);
        chk("mid_rst_busy", e_b, 1'b0);
        rst_n = 1'b1;
        idle(3);
        send(1'b0, 8'h81, evp(8'h81), 1'b1);
        chk("after_rst_data", e_d, 8'h81);
        idle(4);

        chk("q1_drained", q1.size(), 0);
        chk("q4_drained", q4.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fsm_rx.md
Name: fsm_rx

Overview:
Serial frame receiver: the receive end of the one-bit-per-clock 11-bit frame link driven by the FSM transmitter.
- Frame format: start bit (0), 8 data bits with data[0] first, even parity bit, stop bit (1). Line idles high.
- Recovers the byte and checks parity and stop bit.
- Issues a one-cycle valid strobe per frame with error flags.
- Sits on the same clock as the transmitter; used for loopback and for the host-side receive path.

Parameters:
CLKS_PER_BIT, 1, clock cycles per serial bit (>=1); 1 matches the transmitter.
PARITY_ODD, 0, 0 = even parity check (transmitter default), 1 = odd.

Ports:
clk  input  1  system clock; all logic on posedge.
rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
rx_in  input  1  serial line, synchronous to clk, idle high.
data_out  output  [0:7]  received byte; data_out[0] = first data bit received.
data_valid  output  1  one-cycle strobe: data_out/parity_err/frame_err updated this cycle.
parity_err  output  1  parity mismatch on the last frame; valid with data_valid, held until next frame.
frame_err  output  1  stop bit sampled 0 on the last frame; valid with data_valid, held until next frame.
rx_busy  output  1  high from start detection until return to IDLE/SYNC.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low on rst_n.
- Reset (rst_n=0 at a posedge):
  - Outputs: data_out=8'h00, data_valid=0, parity_err=0, frame_err=0, rx_busy=0.
  - Internal: state=SYNC; bit counter, clock counter and shift register cleared.
  - Reset mid-frame discards the partial frame with no strobe.
- States: SYNC, IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
  - SYNC: wait for rx_in=1, then go to IDLE next cycle. This prevents false start after reset while the line is low.
  - IDLE: rx_in=0 sampled at edge T is the start edge; clock counter loads 0.
    - If CLKS_PER_BIT=1: start is confirmed at T; go to DATA.
    - Else go to START.
  - START: at T+(CLKS_PER_BIT-1)/2 (integer division), resample.
    - rx_in=1: false start; return to IDLE, no strobe, no flags changed.
    - rx_in=0: go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles.
    - Data bit k (0..7) is sampled at T+(CLKS_PER_BIT-1)/2+CLKS_PER_BIT*(k+1).
    - Bit k is stored to shift position k.
    - After k=7, go to PARITY.
  - PARITY: sample the parity bit at k=8 spacing, then go to STOP.
  - STOP: sample the stop bit at k=9 spacing. On that same edge:
    - data_out <= byte.
    - parity_err <= (^byte) ^ parity_bit ^ PARITY_ODD.
    - frame_err <= ~stop_bit.
    - data_valid <= 1.
    - Next state: IDLE if stop_bit=1, else BREAK_WAIT.
  - BREAK_WAIT: stay until rx_in=1, then go to IDLE. No strobes while waiting.
- Latency (CLKS_PER_BIT=1): start sampled at edge T, data_valid high in the cycle after edge T+10.
- data_valid is exactly one cycle per accepted frame and never asserted for false starts.
- data_out and the flags hold between frames.
- Back-to-back frames: a start sampled on the edge immediately after the stop sample is accepted, with zero idle cycles. The transmitter's 2-cycle high gap must also be accepted.
- rx_busy: 1 in START/DATA/PARITY/STOP; 0 in IDLE, SYNC, BREAK_WAIT.
- Frames with parity_err or frame_err still deliver data_out. The consumer decides whether to drop them.

Test Plan:
- Reset, rx_in=1, then serial stream 0,1,0,1,1,0,0,1,0,0,1 (byte [0:7]=10110010, parity 0) -> data_valid pulse once, data_out=8'b10110010, parity_err=0, frame_err=0, strobe one cycle after the stop sample.
- Same frame with parity bit flipped to 1 -> data_out=10110010, parity_err=1, frame_err=0.
- Stop bit driven 0 and held low 5 cycles, then high, then a valid frame for byte 8'hA5 -> first strobe has frame_err=1, no strobes during the low hold; second strobe data_out=8'hA5, frame_err=0.
- Loopback with the FSM transmitter: bytes 00, FF, 5A, C3 sent consecutively -> four strobes, exact data, no errors, despite the 2-cycle idle gaps.
- CLKS_PER_BIT=4: 1-cycle low glitch in IDLE -> no strobe, rx_busy pulse only. A full frame for byte 3C at 4 clk/bit -> data_out=3C, no errors.
- rst_n low at the 5th data bit, line held high after release, then a full frame for byte 81 -> no strobe for the aborted frame; outputs zero after reset; next frame data_out=81.
